gate_op_arbiter: RTL and testbench

- Shares one WIDTH-bit bitwise logic unit among NUM_REQ requesters, using round-robin arbitration and a valid/ready handshake.
- Ops: AND, OR, NOT, NAND, NOR, XOR, XNOR, and XOR built from four NANDs.
- One registered response slot; responses carry the requester ID.
- Sits between requester blocks and the shared gate datapath; also self-checks NAND-XOR against native XOR.

---
 rtl/gate_op_arbiter.sv | 166 ++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise gate unit among NUM_REQ requesters.
// One registered response slot; NAND-built XOR is cross-checked against native XOR.
module gate_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     xor_mismatch,
    output logic [15:0]              txn_count
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOT   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_NXOR  = 3'd7
    } op_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              mism_q, mism_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              can_accept_c;
    logic              grant_any_c;
    logic [ID_W-1:0]   grant_idx_c;
    logic [NUM_REQ-1:0] grant_c;

    logic [OP_W-1:0]   sel_op_c;
    logic [WIDTH-1:0]  sel_a_c;
    logic [WIDTH-1:0]  sel_b_c;
    logic [WIDTH-1:0]  nand1_c;
    logic [WIDTH-1:0]  nand_xor_c;
    logic [WIDTH-1:0]  result_c;
    logic              mismatch_c;

    assign can_accept_c = (state_q == EMPTY) || rsp_ready;

    // Scan from last+1 upward, wrapping, for the first valid requester.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        grant_c     = '0;
        if (can_accept_c) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = (32'(last_q) + k) % NUM_REQ;
                if (!grant_any_c && req_valid[ID_W'(idx)]) begin
                    grant_any_c = 1'b1;
                    grant_idx_c = ID_W'(idx);
                end
            end
        end
        if (grant_any_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    assign req_ready = grant_c;

    // Operand mux for the granted requester.
    assign sel_op_c = OP_W'(req_op >> (OP_W * 32'(grant_idx_c)));
    assign sel_a_c  = WIDTH'(req_a >> (WIDTH * 32'(grant_idx_c)));
    assign sel_b_c  = WIDTH'(req_b >> (WIDTH * 32'(grant_idx_c)));

    assign nand1_c    = ~(sel_a_c & sel_b_c);
    assign nand_xor_c = ~(~(sel_a_c & nand1_c) & ~(sel_b_c & nand1_c));
    assign mismatch_c = (nand_xor_c != (sel_a_c ^ sel_b_c));

    always_comb begin
        result_c = '0;
        case (op_e'(sel_op_c))
            OP_AND:  result_c = sel_a_c & sel_b_c;
            OP_OR:   result_c = sel_a_c | sel_b_c;
            OP_NOT:  result_c = ~sel_a_c;
            OP_NAND: result_c = ~(sel_a_c & sel_b_c);
            OP_NOR:  result_c = ~(sel_a_c | sel_b_c);
            OP_XOR:  result_c = sel_a_c ^ sel_b_c;
            OP_XNOR: result_c = ~(sel_a_c ^ sel_b_c);
            OP_NXOR: result_c = nand_xor_c;
            default: result_c = '0;
        endcase
    end

    // Next-state: an accept always fills the slot; otherwise a ready consumer drains it.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        mism_d     = mism_q;
        cnt_d      = cnt_q;
        case (state_q)
            EMPTY: begin
                if (grant_any_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !grant_any_c) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (grant_any_c) begin
            state_d    = FULL;
            last_d     = grant_idx_c;
            rsp_id_d   = grant_idx_c;
            rsp_data_d = result_c;
            mism_d     = mism_q | mismatch_c;
            cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            last_q     <= ID_W'(NUM_REQ - 1);
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            mism_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            mism_q     <= mism_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign xor_mismatch = mism_q;
    assign txn_count    = cnt_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Randomized bench for gate_op_arbiter against a transaction-level reference model.
module tb_gate_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           xor_mismatch;
    logic [15:0]    txn_count;

    int checks;
    int failures;

    // Reference model state
    bit          m_full;
    int          m_last;
    int          m_id;
    logic [7:0]  m_data;
    int          m_cnt;
    bit          m_mis;

    gate_op_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .xor_mismatch (xor_mismatch),
        .txn_count    (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gate(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int model_grant();
        if (m_full && !rsp_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_req(input int i, input bit v, input int op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = v;
        req_op[3*i +: 3] = 3'(op);
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    // Advance the model by one clock edge using current inputs, then advance the DUT.
    task automatic tick();
        int g;
        g = model_grant();
        if (!rst_n) begin
            m_full = 0; m_last = N - 1; m_id = 0; m_data = 8'h00; m_cnt = 0; m_mis = 0;
        end else if (g >= 0) begin
            m_data = gate(int'(req_op[3*g +: 3]), req_a[W*g +: W], req_b[W*g +: W]);
            if ((req_a[W*g +: W] ^ req_b[W*g +: W]) !== gate(7, req_a[W*g +: W], req_b[W*g +: W]))
                m_mis = 1;
            m_id   = g;
            m_last = g;
            m_full = 1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rsp_data); end
        checks++; if (xor_mismatch !== 1'b0) begin failures++; $display("FAIL reset_mis got=%0b exp=0", xor_mismatch); end
        checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", txn_count); end
        rst_n = 1'b1; req_valid = '0;
    endtask

    task automatic test_basic();
        set_req(0, 1, 0, 8'hF0, 8'h3C);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL basic_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL basic_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_data !== 8'h30) begin failures++; $display("FAIL basic_data got=%h exp=30", rsp_data); end
        checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", txn_count); end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'hAA};
        rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            req_valid = '0;
            set_req(2, 1, op, 8'hA5, 8'h0F);
            #1;
            checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL sweep_ready op=%0d got=%b exp=0100", op, req_ready); end
            tick();
            checks++; if (rsp_data !== exp_tab[op] || rsp_id !== 2'd2) begin
                failures++; $display("FAIL sweep_data op=%0d got=%h/id%0d exp=%h/id2", op, rsp_data, rsp_id, exp_tab[op]);
            end
        end
        req_valid = '0;
        checks++; if (xor_mismatch !== 1'b0) begin failures++; $display("FAIL sweep_mis got=%0b exp=0", xor_mismatch); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1, int'($urandom_range(7)), 8'($urandom), 8'($urandom));
            #1;
            checks++; if (req_ready !== 4'(1 << (c % N))) begin
                failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % N)));
            end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % N) || rsp_data !== m_data) begin
                failures++; $display("FAIL rr_rsp cyc=%0d got=%0b/%0d/%h exp=1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, c % N, m_data);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [7:0] held_data;
        logic [1:0] held_id;
        rsp_ready = 1'b1;
        req_valid = '0;
        set_req(0, 1, 1, 8'h12, 8'h48);
        tick();
        req_valid = '0;
        held_data = rsp_data; held_id = rsp_id;
        checks++; if (held_data !== 8'h5A || held_id !== 2'd0) begin failures++; $display("FAIL bp_fill got=%h/%0d exp=5a/0", held_data, held_id); end
        set_req(1, 1, 3, 8'hC3, 8'h99);
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_id !== held_id) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%0b/%h/%0d exp=1/%h/%0d", c, rsp_valid, rsp_data, rsp_id, held_data, held_id);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h7E) begin
            failures++; $display("FAIL bp_new got=%0b/%0d/%h exp=1/1/7e", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'hFF, 8'h0F);
        tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%0b exp=1", rsp_valid); end
        rst_n = 1'b0; rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || txn_count !== 16'd0) begin
            failures++; $display("FAIL mid_reset got=%0b/%0d exp=0/0", rsp_valid, txn_count);
        end
        rst_n = 1'b1;
        req_valid = 4'b1100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_ptr got=%b exp=0100", req_ready); end
        tick();
        checks++; if (rsp_id !== 2'd2 || rsp_data !== 8'h0F) begin failures++; $display("FAIL mid_rsp got=%0d/%h exp=2/0f", rsp_id, rsp_data); end
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'($urandom), int'($urandom_range(7)), 8'($urandom), 8'($urandom));
            rsp_ready = 1'($urandom_range(3) != 0);
            #1;
            checks++; if (req_ready !== model_ready()) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, model_ready());
            end
            tick();
            checks++; if (rsp_valid !== m_full || rsp_id !== 2'(m_id) || rsp_data !== m_data
                         || txn_count !== 16'(m_cnt) || xor_mismatch !== m_mis) begin
                failures++; $display("FAIL rand_rsp cyc=%0d got=%0b/%0d/%h/%0d/%0b exp=%0b/%0d/%h/%0d/%0b", c,
                    rsp_valid, rsp_id, rsp_data, txn_count, xor_mismatch, m_full, m_id, m_data, m_cnt, m_mis);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1, 5, 8'h3C, 8'h66);
        for (int c = 0; c < 65537; c++) tick();
        checks++; if (txn_count !== 16'hFFFF || m_cnt != 65535) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", txn_count); end
        for (int c = 0; c < 3; c++) tick();
        checks++; if (txn_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", txn_count); end
        checks++; if (rsp_data !== 8'h5A || xor_mismatch !== 1'b0) begin failures++; $display("FAIL sat_data got=%h/%0b exp=5a/0", rsp_data, xor_mismatch); end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sat_empty got=%0b exp=0", rsp_valid); end
        tick();
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL sat_ptr got=%b exp=0010", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        m_full = 0; m_last = N - 1; m_id = 0; m_data = 8'h00; m_cnt = 0; m_mis = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_op_sweep();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
